bcd_counter_multi: RTL and testbench

Parametrised multi-digit BCD counter. It generalises the single-digit decade counter to NUM_DIGITS cascaded decades and adds count enable, up/down direction, synchronous parallel load with BCD validation, wrap/saturate mode and a registered rollover pulse. It is intended for event counting and display front-ends, with its count bus driving digit decoders directly.

---
 rtl/bcd_counter_multi_if.sv | 24 ++
 rtl/bcd_counter_multi.sv | 83 ++++++++
 tb/tb_bcd_counter_multi.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bcd_counter_multi_if.sv
// Control and count bus for the multi-decade BCD counter.
// master drives enable/direction/load; slave returns the count and status pulses.
interface bcd_counter_multi_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    carry;
  logic                    zero;
  logic                    load_err;

  modport master (
    output en, up, load, load_val,
    input  count, carry, zero, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output count, carry, zero, load_err
  );
endinterface

// File: rtl/bcd_counter_multi.sv
// Multi-decade BCD up/down counter with validated parallel load,
// wrap or saturate at the limits, and registered carry/load_err pulses.
module bcd_counter_multi #(
  parameter int NUM_DIGITS = 4,
  parameter bit SATURATE   = 1'b0
) (
  input logic              clk,
  input logic              reset,
  bcd_counter_multi_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] count_q;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         carry_q;
  logic         load_err_q;
  logic         all_nine;
  logic         all_zero;
  logic         load_ok;
  logic         inc_c;
  logic         dec_b;

  // Carry and borrow chains are resolved in one pass so every digit updates on the same edge.
  always_comb begin
    inc_val  = count_q;
    dec_val  = count_q;
    all_nine = 1'b1;
    all_zero = 1'b1;
    load_ok  = 1'b1;
    inc_c    = 1'b1;
    dec_b    = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (count_q[4*k +: 4] != 4'd9) all_nine = 1'b0;
      if (count_q[4*k +: 4] != 4'd0) all_zero = 1'b0;
      if (bus.load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
      if (inc_c) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        if (load_ok) count_q <= bus.load_val;
        else         load_err_q <= 1'b1;
      end else if (bus.en) begin
        if (bus.up) begin
          carry_q <= all_nine;
          if (!(SATURATE && all_nine)) count_q <= inc_val;
        end else begin
          carry_q <= all_zero;
          if (!(SATURATE && all_zero)) count_q <= dec_val;
        end
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.carry    = carry_q;
  assign bus.load_err = load_err_q;
  assign bus.zero     = (count_q == '0);
endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench: a wrapping and a saturating two-decade counter share
// the same stimulus and are checked against an integer reference model.
module tb_bcd_counter_multi;
  localparam int ND   = 2;
  localparam int W    = 4 * ND;
  localparam int MAXV = 99;

  typedef struct {
    logic [W-1:0] count;
    logic         carry;
    logic         load_err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_counter_multi_if #(.NUM_DIGITS(ND)) bus_w ();
  bcd_counter_multi_if #(.NUM_DIGITS(ND)) bus_s ();

  bcd_counter_multi #(.NUM_DIGITS(ND), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w));
  bcd_counter_multi #(.NUM_DIGITS(ND), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s));

  exp_t q_w[$];
  exp_t q_s[$];
  int   mw = 0;
  int   ms = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic bit bcd_ok(input logic [W-1:0] v);
    for (int k = 0; k < ND; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = ND - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int t = n;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input bit sat, input bit r, input bit e, input bit u,
                       input bit l, input logic [W-1:0] lv,
                       inout int st, output exp_t x);
    x.carry    = 1'b0;
    x.load_err = 1'b0;
    if (r) st = 0;
    else if (l) begin
      if (bcd_ok(lv)) st = bcd2int(lv);
      else x.load_err = 1'b1;
    end else if (e) begin
      if (u) begin
        if (st == MAXV) begin x.carry = 1'b1; if (!sat) st = 0; end
        else st = st + 1;
      end else begin
        if (st == 0) begin x.carry = 1'b1; if (!sat) st = MAXV; end
        else st = st - 1;
      end
    end
    x.count = int2bcd(st);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input logic [W-1:0] lv);
    exp_t x;
    @(negedge clk);
    reset = r;
    bus_w.en = e; bus_w.up = u; bus_w.load = l; bus_w.load_val = lv;
    bus_s.en = e; bus_s.up = u; bus_s.load = l; bus_s.load_val = lv;
    model(1'b0, r, e, u, l, lv, mw, x); q_w.push_back(x);
    model(1'b1, r, e, u, l, lv, ms, x); q_s.push_back(x);
    @(posedge clk);
    #1;
    x = q_w.pop_front();
    check("wrap.count",    32'(bus_w.count),    32'(x.count));
    check("wrap.carry",    32'(bus_w.carry),    32'(x.carry));
    check("wrap.load_err", 32'(bus_w.load_err), 32'(x.load_err));
    check("wrap.zero",     32'(bus_w.zero),     32'(x.count == '0));
    x = q_s.pop_front();
    check("sat.count",     32'(bus_s.count),    32'(x.count));
    check("sat.carry",     32'(bus_s.carry),    32'(x.carry));
    check("sat.load_err",  32'(bus_s.load_err), 32'(x.load_err));
    check("sat.zero",      32'(bus_s.zero),     32'(x.count == '0));
  endtask

  initial begin
    reset = 1'b1;
    bus_w.en = 1'b0; bus_w.up = 1'b0; bus_w.load = 1'b0; bus_w.load_val = '0;
    bus_s.en = 1'b0; bus_s.up = 1'b0; bus_s.load = 1'b0; bus_s.load_val = '0;

    step(1, 0, 0, 0, 8'h00);
    // count up from zero through 0x12
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 8'h00);
    check("plan1.count", 32'(bus_w.count), 32'h12);

    // upward wrap from 0x98
    step(0, 0, 0, 1, 8'h98);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00);

    // downward through a decade boundary, then past zero
    step(0, 0, 0, 1, 8'h10);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 8'h00);

    // saturating limits on both ends
    step(0, 0, 0, 1, 8'h99);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);

    // rejected load wins over en; valid load wins over en
    step(0, 0, 0, 1, 8'h45);
    step(0, 1, 1, 1, 8'h3A);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h37);
    step(0, 1, 0, 1, 8'hF0);

    // reset beats load and en
    step(0, 0, 0, 1, 8'h50);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 8'h00);
    step(1, 1, 1, 1, 8'h77);
    check("plan6.zero", 32'(bus_w.zero), 32'd1);

    // random mix with direction toggles and invalid loads
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           8'($urandom_range(0, 255)));
    end

    check("queue_empty", 32'(q_w.size() + q_s.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
